// File: rtl/bcd_ctrl_pkg.sv
// Shared encodings and constants for the BCD counter-chain sequencing controller.
package bcd_ctrl_pkg;

    localparam int unsigned DW = 4;

    localparam logic [DW-1:0] BCD_MAX = 4'd9;
    localparam logic [DW-1:0] BCD_MIN = 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic bcd_ok(input logic [DW-1:0] nib);
        return nib <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_count_ctrl_tick_gen.sv
// Step prescaler: counts 0..TICK_DIV-1 while run is high and flags the last count.
module tick_gen #(
    parameter int unsigned TICK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Holding while run is low is what lets a pause resume mid-interval.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign tick = run & (cnt == LAST);

endmodule

// File: rtl/bcd_count_ctrl.sv
// Sequencing controller for a chain of single-digit BCD counters: latches a
// direction and target, strobes the chain with ripple enables, stops on match.
module bcd_count_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned TICK_DIV = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 clear,
    input  logic                 dir,
    input  logic [4*DIGITS-1:0]  target,
    input  logic [4*DIGITS-1:0]  digits_in,
    output logic [DIGITS-1:0]    up_out,
    output logic [DIGITS-1:0]    down_out,
    output logic                 ctr_clr,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           state
);

    localparam int unsigned TW = DW * DIGITS;

    state_t          st;
    logic            dir_l;
    logic [TW-1:0]   tgt_l;

    logic            tick;
    logic            run;
    logic            start_ok;
    logic            tgt_bad;
    logic [DIGITS-1:0] all9;
    logic [DIGITS-1:0] all0;

    always_comb begin
        tgt_bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (!bcd_ok(target[i*DW +: DW])) begin
                tgt_bad = 1'b1;
            end
        end
    end

    // Digit i steps only when every lower digit is about to wrap.
    always_comb begin
        all9 = '0;
        all0 = '0;
        all9[0] = 1'b1;
        all0[0] = 1'b1;
        for (int unsigned i = 1; i < DIGITS; i++) begin
            all9[i] = all9[i-1] & (digits_in[(i-1)*DW +: DW] == BCD_MAX);
            all0[i] = all0[i-1] & (digits_in[(i-1)*DW +: DW] == BCD_MIN);
        end
    end

    assign start_ok = start & ~clear & ~pause & ~tgt_bad &
                      ((st == ST_IDLE) | (st == ST_DONE));
    assign run      = (st == ST_RUN) & ~clear & ~pause;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .clr   (clear | start_ok),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st       <= ST_IDLE;
            dir_l    <= 1'b0;
            tgt_l    <= '0;
            up_out   <= '0;
            down_out <= '0;
            ctr_clr  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            up_out   <= '0;
            down_out <= '0;
            ctr_clr  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            if (clear) begin
                ctr_clr <= 1'b1;
                st      <= ST_IDLE;
                busy    <= 1'b0;
            end else if (pause) begin
                if (st == ST_RUN) begin
                    st <= ST_PAUSED;
                end
            end else begin
                unique case (st)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            if (tgt_bad) begin
                                err <= 1'b1;
                            end else begin
                                dir_l <= dir;
                                tgt_l <= target;
                                st    <= ST_RUN;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    ST_PAUSED: begin
                        if (start) begin
                            st <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (tick) begin
                            if (digits_in == tgt_l) begin
                                done <= 1'b1;
                                st   <= ST_DONE;
                                busy <= 1'b0;
                            end else if (dir_l) begin
                                up_out <= all9;
                            end else begin
                                down_out <= all0;
                            end
                        end
                    end
                    default: st <= ST_IDLE;
                endcase
            end
        end
    end

    assign state = st;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Scoreboard bench for bcd_count_ctrl driving a behavioural two-digit BCD counter bank.
module tb_bcd_count_ctrl;

    localparam int D = 2;
    localparam int T = 2;

    logic         clk = 1'b0;
    logic         reset, start, pause, clear, dir;
    logic [7:0]   target;
    logic [7:0]   bank;
    logic [1:0]   up_out, down_out;
    logic         ctr_clr, busy, done, err;
    logic [1:0]   state;
    logic         load;
    logic [7:0]   load_val;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int         kind;   // 0 strobe, 1 done, 2 err
        logic [1:0] up;
        logic [1:0] dn;
        logic [7:0] val;
        int         at;
        bit         timed;
    } ev_t;

    ev_t q[$];
    ev_t me;
    int  gk;

    always #5 clk = ~clk;

    bcd_count_ctrl #(
        .DIGITS   (D),
        .TICK_DIV (T)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pause     (pause),
        .clear     (clear),
        .dir       (dir),
        .target    (target),
        .digits_in (bank),
        .up_out    (up_out),
        .down_out  (down_out),
        .ctr_clr   (ctr_clr),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .state     (state)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // External counter bank: reset by the system reset or the controller's ctr_clr.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bank <= '0;
        end else if (ctr_clr) begin
            bank <= '0;
        end else if (load) begin
            bank <= load_val;
        end else begin
            for (int i = 0; i < D; i++) begin
                if (up_out[i])
                    bank[i*4 +: 4] <= (bank[i*4 +: 4] == 4'd9) ? 4'd0 : bank[i*4 +: 4] + 4'd1;
                else if (down_out[i])
                    bank[i*4 +: 4] <= (bank[i*4 +: 4] == 4'd0) ? 4'd9 : bank[i*4 +: 4] - 4'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] hi, lo;
        hi = 4'(n / 10);
        lo = 4'(n % 10);
        return {hi, lo};
    endfunction

    // Expected decimal walk from 'from' to 'tgt', one entry per decision.
    task automatic push_run(input logic [7:0] from, input logic [7:0] tgt, input bit up,
                            input int c0, input bit timed);
        int  n, t, k;
        ev_t e;
        n = int'(from[7:4]) * 10 + int'(from[3:0]);
        t = int'(tgt[7:4]) * 10 + int'(tgt[3:0]);
        k = 0;
        while (n != t && k < 200) begin
            e.kind  = 0;
            e.up    = up ? {((n % 10) == 9), 1'b1} : 2'b00;
            e.dn    = up ? 2'b00 : {((n % 10) == 0), 1'b1};
            e.val   = to_bcd(n);
            e.at    = c0 + (k + 1) * T;
            e.timed = timed;
            q.push_back(e);
            n = up ? (n + 1) % 100 : (n + 99) % 100;
            k++;
        end
        e.kind  = 1;
        e.up    = 2'b00;
        e.dn    = 2'b00;
        e.val   = tgt;
        e.at    = c0 + (k + 1) * T;
        e.timed = timed;
        q.push_back(e);
    endtask

    task automatic push_err(input int c0);
        ev_t e;
        e.kind  = 2;
        e.up    = 2'b00;
        e.dn    = 2'b00;
        e.val   = 8'h00;
        e.at    = c0;
        e.timed = 1'b1;
        q.push_back(e);
    endtask

    // Issues a one-cycle start; expectations are queued before the accepting edge.
    task automatic run_cmd(input bit d, input logic [7:0] tg, input logic [7:0] from,
                           input bit is_err, input bit timed);
        int c0;
        @(negedge clk);
        c0 = cyc + 1;
        if (is_err) push_err(c0);
        else        push_run(from, tg, d, c0, timed);
        dir    = d;
        target = tg;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", q.size(), 0);
    endtask

    task automatic load_bank(input logic [7:0] v);
        @(negedge clk);
        load     = 1'b1;
        load_val = v;
        @(negedge clk);
        load     = 1'b0;
        check("load", bank, v);
    endtask

    always @(negedge clk) begin
        if (up_out != 2'b00 || down_out != 2'b00 || done || err) begin
            if (q.size() == 0) begin
                check("unexpected_event", {26'd0, up_out, down_out, done, err}, 32'd0);
            end else begin
                me = q.pop_front();
                gk = done ? 1 : (err ? 2 : 0);
                check("kind", gk, me.kind);
                check("up_out", up_out, me.up);
                check("down_out", down_out, me.dn);
                if (me.kind != 2) check("count", bank, me.val);
                if (me.timed) check("cycle", cyc, me.at);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] snap;
        reset = 1'b1; start = 1'b1; dir = 1'b1; pause = 1'b0; clear = 1'b0;
        target = 8'h00; load = 1'b0; load_val = 8'h00;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_state", state, 2'd0);
            check("rst_busy", busy, 1'b0);
            check("rst_strobes", {up_out, down_out}, 4'h0);
            check("rst_ctr_clr", ctr_clr, 1'b0);
            check("rst_done", done, 1'b0);
        end
        start = 1'b0;
        reset = 1'b0;

        // 00 -> 12 counting up
        run_cmd(1'b1, 8'h12, 8'h00, 1'b0, 1'b1);
        drain(100);
        @(negedge clk);
        check("up_state", state, 2'd3);
        check("up_count", bank, 8'h12);
        check("up_busy", busy, 1'b0);

        // 12 -> 08 counting down from DONE
        run_cmd(1'b0, 8'h08, 8'h12, 1'b0, 1'b1);
        drain(60);
        @(negedge clk);
        check("dn_count", bank, 8'h08);

        // wrap 98 -> 01
        load_bank(8'h98);
        run_cmd(1'b1, 8'h01, 8'h98, 1'b0, 1'b1);
        drain(60);
        @(negedge clk);
        check("wrap_count", bank, 8'h01);
        check("wrap_state", state, 2'd3);

        // pause, resume without re-latch, then clear
        run_cmd(1'b1, 8'h50, 8'h01, 1'b0, 1'b0);
        repeat (7) @(negedge clk);
        pause = 1'b1;
        repeat (2) @(negedge clk);
        snap = bank;
        repeat (8) @(negedge clk);
        check("pause_count", bank, snap);
        check("pause_busy", busy, 1'b1);
        check("pause_state", state, 2'd2);
        pause  = 1'b0;
        dir    = 1'b0;
        target = 8'h00;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        check("resume_state", state, 2'd1);
        repeat (9) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_pulse", ctr_clr, 1'b1);
        check("clr_state", state, 2'd0);
        check("clr_busy", busy, 1'b0);
        check("clr_done", done, 1'b0);
        q.delete();
        @(negedge clk);
        check("clr_pulse_end", ctr_clr, 1'b0);
        check("clr_count", bank, 8'h00);

        // rejected start on non-BCD target
        run_cmd(1'b1, 8'h1A, 8'h00, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        check("err_state", state, 2'd0);
        check("err_busy", busy, 1'b0);
        drain(10);

        // target already reached
        run_cmd(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
        drain(20);
        @(negedge clk);
        check("eq_state", state, 2'd3);
        check("eq_count", bank, 8'h00);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
